tube_array_timer: RTL and testbench

- Multi-channel successor to the single-tube drift counter.
- One instance times N_TUBES drift tubes against a common scintillator trigger, using a fully synchronous datapath: no latches, no gated clocks.
- Each channel records the first cycle its delayed tube signal is high within a fixed window.
- The array then streams one record per channel to the downstream FIFO over a valid/ready handshake.

---
 rtl/tube_array_timer.sv | 165 ++++++++++++++++
 tb/tb_tube_array_timer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tube_array_timer.sv
// Multi-channel drift-tube timer. Each channel latches the first count at which its delayed
// tube level is high after a trigger, then the array streams one record per channel.
// Optional macro TUBE_SYNC_EN inserts a 2-flop synchroniser ahead of each delay line.
module tube_array_timer #(
    parameter int N_TUBES  = 8,
    parameter int CNT_W    = 8,
    parameter int LOOKBACK = 8,
    parameter int WINDOW   = 255,
    localparam int PTR_W   = $clog2(N_TUBES)
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               trig,
    input  logic [N_TUBES-1:0] tube_pin,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PTR_W-1:0]   out_chan,
    output logic [CNT_W-1:0]   out_time,
    output logic               out_hit,
    output logic               out_last,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_READOUT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [PTR_W-1:0]   r_ptr;
    logic [N_TUBES-1:0] r_hit;
    logic [CNT_W-1:0]   r_time [N_TUBES];
    logic [N_TUBES-1:0] r_dl   [LOOKBACK];
    logic [N_TUBES-1:0] w_pin;
    logic [N_TUBES-1:0] w_dly;
    logic               w_cnt_end;
    logic               w_ptr_last;

`ifdef TUBE_SYNC_EN
    logic [N_TUBES-1:0] r_sync1;
    logic [N_TUBES-1:0] r_sync2;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= tube_pin;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pin = r_sync2;
`else
    assign w_pin = tube_pin;
`endif

    // Stage LOOKBACK-1 holds the pin as sampled LOOKBACK edges ago; runs in every state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int k = 0; k < LOOKBACK; k++) begin
                r_dl[k] <= '0;
            end
        end else begin
            r_dl[0] <= w_pin;
            for (int k = 1; k < LOOKBACK; k++) begin
                r_dl[k] <= r_dl[k-1];
            end
        end
    end

    assign w_dly      = r_dl[LOOKBACK-1];
    assign w_cnt_end  = (r_cnt == CNT_W'(WINDOW));
    assign w_ptr_last = (r_ptr == PTR_W'(N_TUBES - 1));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (trig) w_state_next = S_COUNT;
            S_COUNT:   if (w_cnt_end) w_state_next = S_READOUT;
            S_READOUT: if (out_ready && w_ptr_last) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Record fields are forced to zero outside READOUT so idle outputs stay quiet.
    always_comb begin
        busy      = (r_state != S_IDLE);
        out_valid = (r_state == S_READOUT);
        out_chan  = '0;
        out_time  = '0;
        out_hit   = 1'b0;
        out_last  = 1'b0;
        dbg_state = r_state;
        if (r_state == S_READOUT) begin
            out_chan = r_ptr;
            out_time = r_time[r_ptr];
            out_hit  = r_hit[r_ptr];
            out_last = w_ptr_last;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
            r_ptr <= '0;
            r_hit <= '0;
            for (int i = 0; i < N_TUBES; i++) begin
                r_time[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (trig) begin
                        r_cnt <= '0;
                        r_ptr <= '0;
                        r_hit <= '0;
                        for (int i = 0; i < N_TUBES; i++) begin
                            r_time[i] <= '1;
                        end
                    end
                end
                S_COUNT: begin
                    for (int i = 0; i < N_TUBES; i++) begin
                        if (!r_hit[i] && w_dly[i]) begin
                            r_time[i] <= r_cnt;
                            r_hit[i]  <= 1'b1;
                        end
                    end
                    if (w_cnt_end) begin
                        r_ptr <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_READOUT: begin
                    if (out_ready) begin
                        if (w_ptr_last) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= r_ptr + PTR_W'(1);
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;
                    r_ptr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tube_array_timer.sv
// Directed bench for tube_array_timer: idle/reset, single hit, boundary times,
// backpressure with trigger held high, and reset abandoning an event.
module tb_tube_array_timer;

    localparam int N_TUBES  = 8;
    localparam int CNT_W    = 8;
    localparam int LOOKBACK = 8;
    localparam int WINDOW   = 255;
    localparam int PTR_W    = $clog2(N_TUBES);
    localparam int PRE      = 30;
    localparam int NONE     = 100000;
`ifdef TUBE_SYNC_EN
    localparam int SYNC_ADD = 2;
`else
    localparam int SYNC_ADD = 0;
`endif
    localparam int EFF_L    = LOOKBACK + SYNC_ADD;

    logic               clk;
    logic               clr_n;
    logic               trig;
    logic [N_TUBES-1:0] tube_pin;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [PTR_W-1:0]   out_chan;
    logic [CNT_W-1:0]   out_time;
    logic               out_hit;
    logic               out_last;
    logic [1:0]         dbg_state;

    int n_chk = 0;
    int n_err = 0;
    int rise  [N_TUBES];
    int fall  [N_TUBES];
    int exp_t [N_TUBES];
    bit exp_h [N_TUBES];

    tube_array_timer #(
        .N_TUBES(N_TUBES), .CNT_W(CNT_W), .LOOKBACK(LOOKBACK), .WINDOW(WINDOW)
    ) dut (
        .clk(clk), .clr_n(clr_n), .trig(trig), .tube_pin(tube_pin),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_chan(out_chan), .out_time(out_time), .out_hit(out_hit),
        .out_last(out_last), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        for (int i = 0; i < N_TUBES; i++) begin
            rise[i] = NONE;
            fall[i] = NONE;
        end
    endtask

    // Edge r (relative to trigger edge 0) sampled high feeds count c when c+1-EFF_L == r.
    task automatic build_model();
        int r;
        for (int i = 0; i < N_TUBES; i++) begin
            exp_t[i] = (1 << CNT_W) - 1;
            exp_h[i] = 1'b0;
            for (int c = 0; c <= WINDOW; c++) begin
                r = c + 1 - EFF_L;
                if (r >= rise[i] && r < fall[i]) begin
                    exp_t[i] = c;
                    exp_h[i] = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_chan"},  32'(out_chan), 0);
        check({tag, "_time"},  32'(out_time), 0);
        check({tag, "_hit"},   32'(out_hit), 0);
        check({tag, "_last"},  32'(out_last), 0);
        check({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    task automatic check_rec(input string tag, input int k);
        check($sformatf("%s_r%0d_valid", tag, k), 32'(out_valid), 1);
        check($sformatf("%s_r%0d_busy", tag, k),  32'(busy), 1);
        check($sformatf("%s_r%0d_chan", tag, k),  32'(out_chan), 32'(k));
        check($sformatf("%s_r%0d_time", tag, k),  32'(out_time), 32'(exp_t[k]));
        check($sformatf("%s_r%0d_hit", tag, k),   32'(out_hit), 32'(exp_h[k]));
        check($sformatf("%s_r%0d_last", tag, k),  32'(out_last), 32'(k == N_TUBES - 1));
    endtask

    // Drives one event from PRE edges before the trigger through readout.
    task automatic run_event(input string tag, input int abort_at, input bit bp);
        build_model();
        for (int r = -PRE; r <= WINDOW + 1; r++) begin
            for (int i = 0; i < N_TUBES; i++) begin
                tube_pin[i] = (r >= rise[i] && r < fall[i]);
            end
            trig = (r == 0);
            tick();
            check($sformatf("%s_busy_e%0d", tag, r),  32'(busy), 32'(r >= 0));
            check($sformatf("%s_valid_e%0d", tag, r), 32'(out_valid), 32'(r >= WINDOW + 1));
            if (r == abort_at) return;
        end
        tube_pin = '0;
        trig     = bp;
        for (int k = 0; k < N_TUBES; k++) begin
            if (bp && k == 2) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    check_rec($sformatf("%s_hold%0d", tag, s), k);
                    tick();
                end
                out_ready = 1'b1;
            end
            check_rec(tag, k);
            tick();
        end
        check_idle_outputs({tag, "_end"});
    endtask

    initial begin
        clr_n     = 1'b0;
        trig      = 1'b0;
        tube_pin  = '0;
        out_ready = 1'b1;
        clear_sched();

        // Reset and quiet idle
        #1;
        check_idle_outputs("rst");
        repeat (3) tick();
        clr_n = 1'b1;
        repeat (50) tick();
        check_idle_outputs("idle50");

        // Single channel hit, no backpressure
        clear_sched();
        rise[3] = 10;
        run_event("ev1", NONE, 1'b0);

        // Pre-trigger levels, window boundary, second pulse ignored, backpressure
        clear_sched();
        rise[0] = -20;
        rise[1] = -7;  fall[1] = -6;
        rise[2] = 256 - EFF_L;
        rise[4] = 257 - EFF_L;
        rise[6] = 50;  fall[6] = 52;
        rise[7] = 200; fall[7] = 201;
        run_event("ev2", NONE, 1'b1);

        // Trigger held through readout starts a new count only once IDLE is reached
        tick();
        check("ev2_retrig_busy",  32'(busy), 1);
        check("ev2_retrig_state", 32'(dbg_state), 1);
        trig  = 1'b0;
        clr_n = 1'b0;
        #1;
        check_idle_outputs("ev2_abort");
        tick();
        clr_n = 1'b1;
        tick();

        // Reset mid-count with channel 5 already hit
        clear_sched();
        rise[5] = 10;
        run_event("ev3", 100, 1'b0);
        tube_pin = '0;
        clr_n    = 1'b0;
        #1;
        check_idle_outputs("ev3_abort");
        tick();
        clr_n = 1'b1;
        tick();

        // Fresh event with all pins low: nothing carried over
        clear_sched();
        run_event("ev4", NONE, 1'b0);
        check("ev4_ch5_model", 32'(exp_h[5]), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
